// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: constants shared by the fetch queue and its storage.
//   FQ_PC_WIDTH / FQ_INSTR_WIDTH : default datapath widths
//   FQ_RESET_PC                  : default first fetch address after reset
//   TRUE / FALSE                 : single-bit constants
//   PC_INC                       : byte stride between sequential fetch PCs
package fetch_queue_pkg;
  localparam int          FQ_PC_WIDTH    = 32;
  localparam int          FQ_INSTR_WIDTH = 32;
  localparam logic [31:0] FQ_RESET_PC    = 32'h0000_1000;
  localparam logic        TRUE           = 1'b1;
  localparam logic        FALSE          = 1'b0;
  localparam int          PC_INC         = 4;
endpackage

// File: rtl/fetch_queue_circ_buf.sv
// fetch_queue_circ_buf: 2^DEPTH_LOG2-entry dual-field (instr, pc) RAM.
// One write port, OUT_WIDTH show-ahead read lanes starting at i_rd_base.
// Storage has no reset; validity is tracked by the owner's pointers.
//   clk        in  clock
//   i_push     in  write enable
//   i_wr_idx   in  write slot
//   i_wr_instr in  instruction to store
//   i_wr_pc    in  PC to store
//   i_rd_base  in  slot shown on lane 0; lane i shows i_rd_base+i (mod depth)
//   o_rd_instr out per-lane instruction
//   o_rd_pc    out per-lane PC
module fetch_queue_circ_buf
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH_LOG2  = 4,
  parameter int OUT_WIDTH   = 2,
  parameter int PC_WIDTH    = FQ_PC_WIDTH,
  parameter int INSTR_WIDTH = FQ_INSTR_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  i_push,
  input  logic [DEPTH_LOG2-1:0]                 i_wr_idx,
  input  logic [INSTR_WIDTH-1:0]                i_wr_instr,
  input  logic [PC_WIDTH-1:0]                   i_wr_pc,
  input  logic [DEPTH_LOG2-1:0]                 i_rd_base,
  output logic [OUT_WIDTH-1:0][INSTR_WIDTH-1:0] o_rd_instr,
  output logic [OUT_WIDTH-1:0][PC_WIDTH-1:0]    o_rd_pc
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [INSTR_WIDTH-1:0] r_instr [DEPTH];
  logic [PC_WIDTH-1:0]    r_pc    [DEPTH];

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_instr[i_wr_idx] <= i_wr_instr;
      r_pc[i_wr_idx]    <= i_wr_pc;
    end
  end

  // Index arithmetic is DEPTH_LOG2 bits wide so lanes wrap around the ring.
  for (genvar i = 0; i < OUT_WIDTH; i++) begin : g_rd
    logic [DEPTH_LOG2-1:0] w_idx;
    assign w_idx         = i_rd_base + DEPTH_LOG2'(i);
    assign o_rd_instr[i] = r_instr[w_idx];
    assign o_rd_pc[i]    = r_pc[w_idx];
  end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch queue between fetcher (fc), decoder (dc)
// and ROB. Issues sequential fetch PCs, buffers in-order responses with
// their PCs, shows up to OUT_WIDTH oldest entries to the decoder, and on a
// ROB redirect flushes and drops responses still in flight for the old path.
// Optional build macro FETCH_QUEUE_BYPASS_EN: an accepted response arriving
// at an empty queue is shown on lane 0 in the same cycle.
//   clk, rst           clock, synchronous active-high reset
//   flush_from_rob     redirect pulse, pc_from_rob is the new fetch target
//   req_valid_to_fc    fetch request valid, pc_to_fc its address
//   req_ready_from_fc  fetcher accepts the request
//   resp_valid_from_fc in-order response, instr_from_fc its instruction
//   lane_valid_to_dc   lane i holds the i-th oldest entry
//   instr_to_dc        lane-packed instructions, lane 0 in LSBs
//   pc_to_dc           lane-packed PCs, lane 0 in LSBs
//   take_from_dc       lanes consumed this cycle
//   count_out          current occupancy
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                  DEPTH_LOG2   = 4,
  parameter int                  OUT_WIDTH    = 2,
  parameter int                  MAX_INFLIGHT = 4,
  parameter int                  PC_WIDTH     = FQ_PC_WIDTH,
  parameter int                  INSTR_WIDTH  = FQ_INSTR_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC     = PC_WIDTH'(FQ_RESET_PC)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush_from_rob,
  input  logic [PC_WIDTH-1:0]              pc_from_rob,
  output logic                             req_valid_to_fc,
  output logic [PC_WIDTH-1:0]              pc_to_fc,
  input  logic                             req_ready_from_fc,
  input  logic                             resp_valid_from_fc,
  input  logic [INSTR_WIDTH-1:0]           instr_from_fc,
  output logic [OUT_WIDTH-1:0]             lane_valid_to_dc,
  output logic [OUT_WIDTH*INSTR_WIDTH-1:0] instr_to_dc,
  output logic [OUT_WIDTH*PC_WIDTH-1:0]    pc_to_dc,
  input  logic [$clog2(OUT_WIDTH+1)-1:0]   take_from_dc,
  output logic [DEPTH_LOG2:0]              count_out
);
  localparam int PW    = DEPTH_LOG2 + 1;            // pointer width with wrap bit
  localparam int IW    = $clog2(MAX_INFLIGHT + 1);
  localparam int TW    = $clog2(OUT_WIDTH + 1);
  localparam int SW    = ((PW > IW) ? PW : IW) + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [PW-1:0]       r_head, r_tail;
  logic [IW-1:0]       r_inflight, r_drop_cnt;
  logic [PC_WIDTH-1:0] r_pc_fc, r_fill_pc;

  logic [PW-1:0]       w_count;
  logic                w_empty;
  logic [SW-1:0]       w_occ;
  logic                w_req_valid, w_req_fire;
  logic                w_accept, w_bypass, w_push;
  logic [TW-1:0]       w_pop;

  logic [OUT_WIDTH-1:0][INSTR_WIDTH-1:0] w_rd_instr, w_lane_instr;
  logic [OUT_WIDTH-1:0][PC_WIDTH-1:0]    w_rd_pc, w_lane_pc;
  logic [OUT_WIDTH-1:0]                  w_lane_valid;

  // Wrap-bit pointers: equal means empty, equal low bits with differing MSB
  // means full. The difference is the occupancy directly.
  assign w_count = r_tail - r_head;
  assign w_empty = (r_head == r_tail);

  // Reserve a slot for every live in-flight request so responses can never
  // overflow the ring; requests doomed to be dropped hold no slot.
  assign w_occ       = SW'(w_count) + SW'(r_inflight) - SW'(r_drop_cnt);
  assign w_req_valid = !rst && !flush_from_rob && (w_occ < SW'(DEPTH)) &&
                       (r_inflight < IW'(MAX_INFLIGHT));
  assign w_req_fire  = w_req_valid && req_ready_from_fc;

  assign w_accept = resp_valid_from_fc && (r_drop_cnt == '0) && !flush_from_rob;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_accept && w_empty;
  // A bypassed entry taken this cycle is never written to the ring.
  assign w_push   = w_accept && !(w_bypass && (take_from_dc != '0));
`else
  assign w_bypass = FALSE;
  assign w_push   = w_accept;
`endif

  assign w_pop = w_bypass ? '0 : take_from_dc;

  fetch_queue_circ_buf #(
    .DEPTH_LOG2  (DEPTH_LOG2),
    .OUT_WIDTH   (OUT_WIDTH),
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_buf (
    .clk        (clk),
    .i_push     (w_push),
    .i_wr_idx   (r_tail[PW-2:0]),
    .i_wr_instr (instr_from_fc),
    .i_wr_pc    (r_fill_pc),
    .i_rd_base  (r_head[PW-2:0]),
    .o_rd_instr (w_rd_instr),
    .o_rd_pc    (w_rd_pc)
  );

  always_comb begin
    w_lane_valid = '0;
    w_lane_instr = w_rd_instr;
    w_lane_pc    = w_rd_pc;
    for (int i = 0; i < OUT_WIDTH; i++)
      w_lane_valid[i] = (w_count > PW'(i));
    if (w_bypass) begin
      w_lane_valid[0] = TRUE;
      w_lane_instr[0] = instr_from_fc;
      w_lane_pc[0]    = r_fill_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_inflight <= '0;
      r_drop_cnt <= '0;
      r_pc_fc    <= RESET_PC;
      r_fill_pc  <= RESET_PC;
    end else if (flush_from_rob) begin
      // No request fires here and any response is discarded, so every
      // request still outstanding after this edge belongs to the old path.
      r_head     <= r_tail;
      r_pc_fc    <= pc_from_rob;
      r_fill_pc  <= pc_from_rob;
      r_inflight <= r_inflight - IW'(resp_valid_from_fc);
      r_drop_cnt <= r_inflight - IW'(resp_valid_from_fc);
    end else begin
      r_head     <= r_head + PW'(w_pop);
      if (w_push)     r_tail    <= r_tail + PW'(1);
      if (w_accept)   r_fill_pc <= r_fill_pc + PC_WIDTH'(PC_INC);
      if (w_req_fire) r_pc_fc   <= r_pc_fc + PC_WIDTH'(PC_INC);
      r_inflight <= r_inflight + IW'(w_req_fire) - IW'(resp_valid_from_fc);
      if (resp_valid_from_fc && (r_drop_cnt != '0))
        r_drop_cnt <= r_drop_cnt - IW'(1);
    end
  end

  assign req_valid_to_fc  = w_req_valid;
  assign pc_to_fc         = r_pc_fc;
  assign lane_valid_to_dc = w_lane_valid;
  assign instr_to_dc      = w_lane_instr;
  assign pc_to_dc         = w_lane_pc;
  assign count_out        = w_count;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed bench for fetch_queue (default parameters).
// The bench plays the fetcher: fired request PCs are queued and returned
// in order, instruction = pc ^ 32'hDEAD0000. Expected values are hand-derived.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] rob_pc = '0;
  logic        req_valid;
  logic [31:0] pc_fc;
  logic        req_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [1:0]  lane_valid;
  logic [63:0] instr_dc, pc_dc;
  logic [1:0]  take = '0;
  logic [4:0]  count;

  int          checks = 0, failures = 0;
  logic [31:0] pend[$];
  bit          auto_resp = 1'b0;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk                (clk),
    .rst                (rst),
    .flush_from_rob     (flush),
    .pc_from_rob        (rob_pc),
    .req_valid_to_fc    (req_valid),
    .pc_to_fc           (pc_fc),
    .req_ready_from_fc  (req_ready),
    .resp_valid_from_fc (resp_valid),
    .instr_from_fc      (instr),
    .lane_valid_to_dc   (lane_valid),
    .instr_to_dc        (instr_dc),
    .pc_to_dc           (pc_dc),
    .take_from_dc       (take),
    .count_out          (count)
  );

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return pc ^ 32'hDEAD0000;
  endfunction

  function automatic int popc();
    int n = 0;
    for (int i = 0; i < 2; i++) n += int'(lane_valid[i]);
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive the fetcher response for this cycle, then let logic settle.
  task automatic prep();
    if (auto_resp) begin
      resp_valid = (pend.size() > 0);
      instr      = (pend.size() > 0) ? ins_of(pend[0]) : 32'h0;
    end
    #2;
  endtask

  // Clock edge: record handshakes seen before the edge into the fetcher model.
  task automatic tick();
    logic        fire;
    logic [31:0] p;
    logic        rv;
    fire = req_valid && req_ready;
    p    = pc_fc;
    rv   = resp_valid && auto_resp;
    check("take_rule", (int'(take) <= popc()) ? 32'd1 : 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (rv && pend.size() > 0) void'(pend.pop_front());
    if (fire) pend.push_back(p);
  endtask

  task automatic step();
    prep();
    tick();
  endtask

  task automatic do_reset(input bit chk);
    rst = 1'b1; auto_resp = 1'b0; resp_valid = 1'b0; req_ready = 1'b0;
    take = '0; flush = 1'b0;
    pend.delete();
    step();
    prep();
    if (chk) begin
      check("rst_count", 32'(count), 32'd0);
      check("rst_lanes", 32'(lane_valid), 32'd0);
      check("rst_req_valid", 32'(req_valid), 32'd0);
      check("rst_pc", pc_fc, 32'h1000);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pc;
    int ndisp, budget, t, p;

    // 1: fill to full, fetcher always ready, no dispatch.
    do_reset(1'b1);
    req_ready = 1'b1; auto_resp = 1'b1;
    prep(); check("t1_pc0", pc_fc, 32'h1000); check("t1_req0", 32'(req_valid), 32'd1); tick();
    prep(); check("t1_pc1", pc_fc, 32'h1004); tick();
    prep(); check("t1_pc2", pc_fc, 32'h1008); tick();
    for (int k = 0; k < 14; k++) step();
    prep();
    check("t1_full_count", 32'(count), 32'd16);
    check("t1_full_noreq", 32'(req_valid), 32'd0);
    check("t1_lanes", 32'(lane_valid), 32'd3);
    check("t1_l0_pc", pc_dc[31:0], 32'h1000);
    check("t1_l1_pc", pc_dc[63:32], 32'h1004);
    check("t1_l1_instr", instr_dc[63:32], 32'hDEAD1004);
    tick();

    // 2: five entries drained two at a time.
    do_reset(1'b0);
    req_ready = 1'b1; auto_resp = 1'b1;
    for (int k = 0; k < 5; k++) step();
    req_ready = 1'b0;
    step();
    take = 2'd2;
    prep();
    check("t2_count5", 32'(count), 32'd5);
    check("t2_a_l0", pc_dc[31:0], 32'h1000);
    check("t2_a_l1", pc_dc[63:32], 32'h1004);
    tick();
    prep();
    check("t2_count3", 32'(count), 32'd3);
    check("t2_b_l0", pc_dc[31:0], 32'h1008);
    check("t2_b_l1", pc_dc[63:32], 32'h100C);
    tick();
    take = 2'd1;
    prep();
    check("t2_lanes_one", 32'(lane_valid), 32'd1);
    check("t2_c_l0", pc_dc[31:0], 32'h1010);
    tick();
    take = 2'd0;
    prep(); check("t2_empty", 32'(count), 32'd0); check("t2_no_lanes", 32'(lane_valid), 32'd0); tick();
    prep(); check("t2_no_underflow", 32'(count), 32'd0); tick();

    // 3: three in flight, redirect drops exactly three responses.
    do_reset(1'b0);
    req_ready = 1'b1; auto_resp = 1'b0;
    step(); step(); step();
    req_ready = 1'b0; flush = 1'b1; rob_pc = 32'h2000;
    prep(); check("t3_flush_noreq", 32'(req_valid), 32'd0); tick();
    flush = 1'b0; req_ready = 1'b1; auto_resp = 1'b1;
    prep(); check("t3_pc_restart", pc_fc, 32'h2000); check("t3_req_resume", 32'(req_valid), 32'd1); tick();
    prep(); check("t3_pc_next", pc_fc, 32'h2004); tick();
    prep(); tick();
    prep(); check("t3_drops_empty", 32'(count), 32'd0); tick();
    req_ready = 1'b0;
    prep();
    check("t3_count1", 32'(count), 32'd1);
    check("t3_l0_pc", pc_dc[31:0], 32'h2000);
    check("t3_l0_instr", instr_dc[31:0], 32'hDEAD2000);
    tick();

    // 4: flush with simultaneous response and request handshake.
    do_reset(1'b0);
    req_ready = 1'b1; auto_resp = 1'b0;
    step(); step();
    auto_resp = 1'b1; flush = 1'b1; rob_pc = 32'h3000;
    prep(); check("t4_flush_noreq", 32'(req_valid), 32'd0); tick();
    flush = 1'b0;
    prep();
    check("t4_flushed", 32'(count), 32'd0);
    check("t4_pc", pc_fc, 32'h3000);
    check("t4_req", 32'(req_valid), 32'd1);
    tick();
    prep(); check("t4_no_stale", 32'(count), 32'd0); tick();
    req_ready = 1'b0;
    prep();
    check("t4_count1", 32'(count), 32'd1);
    check("t4_l0_pc", pc_dc[31:0], 32'h3000);
    check("t4_l0_instr", instr_dc[31:0], 32'hDEAD3000);
    tick();

    // 5: wrap-around with random takes, then fill to full and drain.
    do_reset(1'b0);
    req_ready = 1'b1; auto_resp = 1'b1;
    exp_pc = 32'h1000; ndisp = 0; budget = 0;
    while (ndisp < 40 && budget < 500) begin
      prep();
      p = popc();
      t = int'($urandom_range(0, 2));
      if (t > p) t = p;
      take = 2'(t);
      for (int i = 0; i < t; i++) begin
        check("t5_pc", pc_dc[i*32 +: 32], exp_pc);
        check("t5_instr", instr_dc[i*32 +: 32], ins_of(exp_pc));
        exp_pc += 32'd4; ndisp++;
      end
      tick();
      budget++;
    end
    check("t5_progress", (ndisp >= 40) ? 32'd1 : 32'd0, 32'd1);
    take = 2'd0;
    budget = 0;
    prep();
    while (count != 5'd16 && budget < 100) begin tick(); prep(); budget++; end
    check("t5_wrap_full", 32'(count), 32'd16);
    tick(); prep();
    check("t5_full_noreq", 32'(req_valid), 32'd0);
    check("t5_full_hold", 32'(count), 32'd16);
    tick();
    req_ready = 1'b0;
    budget = 0;
    prep();
    while (count != 5'd0 && budget < 100) begin
      t = popc(); if (t > 2) t = 2;
      take = 2'(t);
      for (int i = 0; i < t; i++) begin
        check("t5_drain_pc", pc_dc[i*32 +: 32], exp_pc);
        exp_pc += 32'd4;
      end
      tick(); prep(); budget++;
    end
    take = 2'd0;
    check("t5_drained", 32'(count), 32'd0);
    check("t5_drained_lanes", 32'(lane_valid), 32'd0);
    tick();

    // 6: response into an empty queue.
    do_reset(1'b0);
    req_ready = 1'b1; auto_resp = 1'b0;
    step();
    req_ready = 1'b0; resp_valid = 1'b1; instr = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
    take = 2'd1;
    prep();
    check("t6_byp_valid", 32'(lane_valid[0]), 32'd1);
    check("t6_byp_pc", pc_dc[31:0], 32'h1000);
    check("t6_byp_instr", instr_dc[31:0], 32'h0000_0013);
    tick();
    resp_valid = 1'b0; take = 2'd0;
    prep();
    check("t6_byp_count", 32'(count), 32'd0);
    check("t6_byp_lanes", 32'(lane_valid), 32'd0);
    tick();
`else
    take = 2'd0;
    prep(); check("t6_not_same_cycle", 32'(lane_valid[0]), 32'd0); tick();
    resp_valid = 1'b0;
    prep();
    check("t6_valid_next", 32'(lane_valid), 32'd1);
    check("t6_pc", pc_dc[31:0], 32'h1000);
    check("t6_instr", instr_dc[31:0], 32'h0000_0013);
    check("t6_count", 32'(count), 32'd1);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
